matchstick_panel_io: RTL and testbench
======================================

// Module: matchstick_panel_io
// PURPOSE
//  Front-panel I/O block for the matchstick game. It debounces two active-low pushbuttons.
//  On each confirmed press of button 1 it latches the 4-bit DIP-switch value.
//  It drives a 4-digit multiplexed 7-segment display showing the player turn and the
//  remaining stick count. It sits between the board pins and the game FSM: the FSM
//  consumes the press pulses and entered_num, and supplies turn, sum and correctness.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  cycles a synced button level must stay stable before it is accepted (>=2)
//  REFRESH_CYCLES   50000   cycles each display digit stays selected before the scan advances (>=1)
// PORTS
//  clk          in   1  single clock; every register is clocked on its rising edge
//  rst          in   1  synchronous reset, active-high
//  pushbutton1  in   1  raw button 1 (enter move), active-low, asynchronous
//  pushbutton2  in   1  raw button 2 (game restart), active-low, asynchronous
//  ds           in   4  DIP switches, unsigned move value
//  turn         in   4  current player; shown as a hex glyph
//  sum          in   8  remaining sticks, unsigned 0..255
//  correctness  in   1  1 = last move legal, 0 = illegal
//  pb1_db       out  1  debounced level of button 1 (1 = pressed)
//  pb2_db       out  1  debounced level of button 2 (1 = pressed)
//  pb1_pulse    out  1  one-cycle strobe on each accepted press of button 1
//  pb2_pulse    out  1  one-cycle strobe on each accepted press of button 2
//  entered_num  out  4  ds value captured on the pb1 press
//  grounds      out  4  digit enables, active-low; bit0 = rightmost digit
//  display      out  7  segments {a,b,c,d,e,f,g} = bits [6:0], active-low
// BEHAVIOUR
//  Reset (rst=1 at a clk edge) forces all of the following; rst has priority over all other activity:
//    - pb*_db=0, pb*_pulse=0, entered_num=0
//    - debounce counters=0, synchronizers=0, scan index=0, refresh counter=0
//    - grounds=4'b1111, display=7'b1111111
//  Debounce, per button, identical logic:
//    - raw inverted, then passed through a 2-flop synchronizer -> s
//    - s==db: counter cleared
//    - s!=db: counter increments; when it reaches DEBOUNCE_CYCLES-1, db<=s and counter clears
//    - any bounce back resets the count
//    - press latency = 2 sync cycles + DEBOUNCE_CYCLES clocks
//  Pulses and capture:
//    - pbN_pulse=1 for exactly the one clock in which db goes 0->1; never on release
//    - on that same edge entered_num<=ds
//    - entered_num holds otherwise, including when pb2 is pressed
//    - the two buttons are fully independent; a simultaneous press gives both pulses in the same cycle
//  Display scan:
//    - refresh counter counts 0..REFRESH_CYCLES-1; on wrap, index advances 0->1->2->3->0
//    - grounds and display are registered from the current index and inputs: 1 cycle latency
//    - grounds = ~(4'b0001 << index)
//  Digit content:
//    - sum is converted to decimal H,T,O with combinational math, valid over 0..255
//    - digit0 = O; digit1 = T; digit2 = H; digit3 = glyph(turn[3:0])
//    - correctness=0: digits 0..2 show dash 7'b1111110 instead of the count; digit3 still shows turn
//  Glyphs, active-low, 0..F:
//    0000001 1001111 0010010 0000110 1001100 0100100 0100000 0001111
//    0000000 0000100 0001000 1100000 0110001 1000010 0110000 0111000
//    blank = 7'b1111111
//  Reset mid-scan or mid-debounce: state is discarded; the next press needs a full DEBOUNCE_CYCLES.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - digit2 blank when H==0
//    - digit1 blank when H==0 && T==0
//    - digit0 always shown
//    - dashes (correctness=0) are never blanked
//  LEADING_ZERO_BLANK_EN undefined: all three count digits always shown, e.g. sum=7 -> "007".
// TESTING
//  Use DEBOUNCE_CYCLES=4, REFRESH_CYCLES=2.
//  1. Reset: hold rst 2 cycles -> grounds=1111, display=1111111, entered_num=0.
//     First scan after release -> grounds=1110.
//  2. ds=4'd3; hold pushbutton1 low 10 cycles -> exactly one pb1_pulse, entered_num=3.
//     Then release -> no pulse; entered_num stays 3.
//  3. Toggle pushbutton1 every 2 cycles for 20 cycles -> pb1_db stays 0, no pulse, entered_num unchanged.
//  4. sum=100, turn=1, correctness=1, scan 4 digits ->
//     digit0 0000001, digit1 0000001, digit2 1001111, digit3 1001111.
//     correctness=0 -> digits 0..2 show 1111110.
//  5. With LEADING_ZERO_BLANK_EN, sum=7 -> digit2 and digit1 blank, digit0 = 0001111.
//     Without it -> digit2 and digit1 show 0000001.
//  6. Press both buttons together -> pb1_pulse and pb2_pulse in the same cycle.
//     Assert rst during a press -> both pb*_db return to 0 on the next edge.

Source files
------------

// File: rtl/matchstick_panel_io.sv
// -----------------------------------------------------------------------------
// matchstick_panel_io
//
// Front-panel I/O for the matchstick game. It debounces the two active-low
// pushbuttons and raises a one-cycle strobe on each accepted press. On a
// button-1 press it captures the DIP-switch value into entered_num. It also
// scans a 4-digit multiplexed 7-segment display that shows the player turn
// and the remaining stick count in decimal.
//
// Optional feature (compile-time macro):
//   LEADING_ZERO_BLANK_EN - blank leading zeros of the stick count
//                           (digit2 when H==0, digit1 when H==0 && T==0).
//                           When undefined, all three count digits are shown.
//
// Parameters:
//   DEBOUNCE_CYCLES - cycles a synced level must stay stable (>=2)
//   REFRESH_CYCLES  - cycles each digit stays selected (>=1)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pushbutton1/pushbutton2   raw active-low buttons (asynchronous)
//   ds[3:0]                   DIP switches (move value)
//   turn[3:0]                 current player, shown as a hex glyph on digit3
//   sum[7:0]                  remaining sticks, shown as H,T,O on digits 2..0
//   correctness               0 -> digits 2..0 show a dash
//   pb1_db/pb2_db             debounced levels (1 = pressed)
//   pb1_pulse/pb2_pulse       one-cycle strobe on each accepted press
//   entered_num[3:0]          ds captured on the pb1 press
//   grounds[3:0]              digit enables, active-low, bit0 = rightmost
//   display[6:0]              segments {a..g}, active-low
// -----------------------------------------------------------------------------
module matchstick_panel_io #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pushbutton1,
    input  logic       pushbutton2,
    input  logic [3:0] ds,
    input  logic [3:0] turn,
    input  logic [7:0] sum,
    input  logic       correctness,
    output logic       pb1_db,
    output logic       pb2_db,
    output logic       pb1_pulse,
    output logic       pb2_pulse,
    output logic [3:0] entered_num,
    output logic [3:0] grounds,
    output logic [6:0] display
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RF_W-1:0] RF_MAX = RF_W'(REFRESH_CYCLES - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // ------------------------------------------------------------------
    // Debounce: one identical channel per button
    // ------------------------------------------------------------------
    logic [1:0] pressed_raw;
    logic [1:0] db_vec;
    logic [1:0] pulse_vec;
    logic [1:0] rise_vec;

    // Buttons are active-low; invert so that 1 means pressed.
    assign pressed_raw = {~pushbutton2, ~pushbutton1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic            pulse_reg;
            logic [DB_W-1:0] cnt_reg;

            // The counter reaching its limit while the synced level is high
            // and the accepted level is low is exactly the 0->1 transition.
            assign rise_vec[gi] = sync2_reg & ~db_reg & (cnt_reg == DB_MAX);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= pressed_raw[gi];
                    sync2_reg <= sync1_reg;
                    pulse_reg <= rise_vec[gi];
                    if (sync2_reg == db_reg) begin
                        // Agreement (or a bounce back) discards any partial count.
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_MAX) begin
                        db_reg  <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign db_vec[gi]    = db_reg;
            assign pulse_vec[gi] = pulse_reg;
        end
    endgenerate

    assign pb1_db    = db_vec[0];
    assign pb2_db    = db_vec[1];
    assign pb1_pulse = pulse_vec[0];
    assign pb2_pulse = pulse_vec[1];

    // Capture on the same edge that raises pb1_pulse.
    logic [3:0] entered_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            entered_reg <= 4'd0;
        end else if (rise_vec[0]) begin
            entered_reg <= ds;
        end
    end

    assign entered_num = entered_reg;

    // ------------------------------------------------------------------
    // Stick count to decimal digits
    // ------------------------------------------------------------------
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_h;
    logic       blank_t;

    assign hundreds = 4'(sum / 8'd100);
    assign tens     = 4'((sum / 8'd10) % 8'd10);
    assign ones     = 4'(sum % 8'd10);

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_h = (hundreds == 4'd0);
    assign blank_t = (hundreds == 4'd0) && (tens == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [RF_W-1:0] refresh_reg;
    logic [1:0]      scan_idx_reg;
    logic [3:0]      grounds_reg;
    logic [6:0]      display_reg;
    logic [3:0]      grounds_next;
    logic [6:0]      display_next;

    assign grounds_next = ~(4'b0001 << scan_idx_reg);

    always_comb begin
        display_next = SEG_BLANK;
        case (scan_idx_reg)
            2'd0:    display_next = correctness ? glyph(ones) : SEG_DASH;
            2'd1:    display_next = !correctness ? SEG_DASH :
                                    (blank_t ? SEG_BLANK : glyph(tens));
            2'd2:    display_next = !correctness ? SEG_DASH :
                                    (blank_h ? SEG_BLANK : glyph(hundreds));
            default: display_next = glyph(turn);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_reg  <= '0;
            scan_idx_reg <= 2'd0;
            grounds_reg  <= 4'b1111;
            display_reg  <= SEG_BLANK;
        end else begin
            grounds_reg <= grounds_next;
            display_reg <= display_next;
            if (refresh_reg == RF_MAX) begin
                refresh_reg  <= '0;
                scan_idx_reg <= scan_idx_reg + 2'd1;
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end
        end
    end

    assign grounds = grounds_reg;
    assign display = display_reg;

endmodule

// File: tb/tb_matchstick_panel_io.sv
module tb_matchstick_panel_io;

    localparam int DB = 4;
    localparam int RF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pushbutton1 = 1'b1;
    logic       pushbutton2 = 1'b1;
    logic [3:0] ds = 4'd0;
    logic [3:0] turn = 4'd0;
    logic [7:0] sum = 8'd0;
    logic       correctness = 1'b1;
    logic       pb1_db, pb2_db, pb1_pulse, pb2_pulse;
    logic [3:0] entered_num;
    logic [3:0] grounds;
    logic [6:0] display;

    matchstick_panel_io #(
        .DEBOUNCE_CYCLES(DB),
        .REFRESH_CYCLES (RF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pushbutton1(pushbutton1),
        .pushbutton2(pushbutton2),
        .ds         (ds),
        .turn       (turn),
        .sum        (sum),
        .correctness(correctness),
        .pb1_db     (pb1_db),
        .pb2_db     (pb2_db),
        .pb1_pulse  (pb1_pulse),
        .pb2_pulse  (pb2_pulse),
        .entered_num(entered_num),
        .grounds    (grounds),
        .display    (display)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       p1;
        logic       p2;
        logic [3:0] num;
    } ev_t;

    ev_t        exp_q[$];
    logic [3:0] model_num = 4'd0;
    bit         done = 1'b0;

    logic [6:0] glyph_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference digit content: decimal place value of the count, dash when
    // the move was illegal, hex glyph of the turn on the leftmost digit.
    function automatic logic [6:0] exp_seg(input int pos, input logic [7:0] s,
                                           input logic [3:0] t, input logic c);
        int divisor;
        int digit;
        if (pos == 3) return glyph_tab[t];
        if (!c) return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && s < 100) return 7'b1111111;
        if (pos == 1 && s < 10) return 7'b1111111;
`endif
        divisor = (pos == 0) ? 1 : ((pos == 1) ? 10 : 100);
        digit = (int'(s) / divisor) % 10;
        return glyph_tab[digit];
    endfunction

    // Values the DUT saw at the most recent rising edge.
    logic       rst_s = 1'b1;
    logic [7:0] sum_s;
    logic [3:0] turn_s;
    logic       corr_s;

    always @(posedge clk) begin
        rst_s  = rst;
        sum_s  = sum;
        turn_s = turn;
        corr_s = correctness;
    end

    // Display monitor: digit content and scan order/dwell.
    logic [3:0] cur_g = 4'hf;
    int         dwell = 0;
    bit         first_grp = 1'b1;

    always @(negedge clk) begin
        int pos;
        pos = -1;
        if (rst_s) begin
            check_eq("rst_grounds", grounds, 4'hf);
            check_eq("rst_display", display, 7'h7f);
            check_eq("rst_db", {pb1_db, pb2_db, pb1_pulse, pb2_pulse}, 0);
            check_eq("rst_entered", entered_num, 0);
            cur_g = 4'hf;
            dwell = 0;
            first_grp = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (grounds == ~(4'b0001 << i)) pos = i;
            check_eq("grounds_valid", grounds, (pos >= 0) ? grounds : 4'he);
            if (pos >= 0) begin
                if (grounds != cur_g) begin
                    if (cur_g == 4'hf) begin
                        check_eq("scan_first", grounds, 4'he);
                    end else begin
                        check_eq("scan_order", grounds, {cur_g[2:0], cur_g[3]});
                        if (!first_grp) check_eq("scan_dwell", dwell, RF);
                    end
                    first_grp = (cur_g == 4'hf);
                    cur_g = grounds;
                    dwell = 1;
                end else begin
                    dwell++;
                end
                check_eq($sformatf("digit%0d sum=%0d turn=%0d c=%0d", pos, sum_s, turn_s, corr_s),
                         display, exp_seg(pos, sum_s, turn_s, corr_s));
            end
        end
    end

    // Pulse monitor: each strobe pops one expected press event.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_s && (pb1_pulse || pb2_pulse)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {pb1_pulse, pb2_pulse}, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pulse_pb1", pb1_pulse, e.p1);
                check_eq("pulse_pb2", pb2_pulse, e.p2);
                check_eq("entered_num", entered_num, e.num);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A press held for at least DB cycles is accepted exactly once.
    task automatic press(input int mask, input logic [3:0] d, input int len, input int gap);
        ev_t e;
        ds = d;
        pushbutton1 = !mask[0];
        pushbutton2 = !mask[1];
        if (len >= DB) begin
            if (mask[0]) model_num = d;
            e.p1  = mask[0];
            e.p2  = mask[1];
            e.num = model_num;
            exp_q.push_back(e);
        end
        cyc(len);
        pushbutton1 = 1'b1;
        pushbutton2 = 1'b1;
        cyc(gap);
    endtask

    // Display input stimulus.
    initial begin
        cyc(1);
        sum = 8'd100; turn = 4'd1; correctness = 1'b1; cyc(12);
        correctness = 1'b0; cyc(12);
        sum = 8'd7; correctness = 1'b1; cyc(12);
        sum = 8'd255; turn = 4'd15; cyc(12);
        sum = 8'd0; turn = 4'd0; cyc(12);
        sum = 8'd10; turn = 4'd10; cyc(12);
        while (!done) begin
            sum = 8'($urandom);
            turn = 4'($urandom);
            correctness = ($urandom_range(0, 3) != 0);
            cyc($urandom_range(3, 12));
        end
    end

    // Button stimulus.
    initial begin
        ev_t e;
        cyc(2);
        rst = 1'b0;
        cyc(2);

        press(1, 4'd3, 10, 8);
        check_eq("after_release_num", entered_num, 3);
        check_eq("after_release_db", pb1_db, 0);

        repeat (5) press(1, 4'($urandom), 2, 2);
        check_eq("toggle_db", pb1_db, 0);
        check_eq("toggle_num", entered_num, 3);
        cyc(6);

        press(2, 4'd12, 6, 8);
        check_eq("pb2_keeps_num", entered_num, 3);

        press(3, 4'd5, 7, 8);

        for (int k = 0; k < 30; k++)
            press($urandom_range(1, 3), 4'($urandom), $urandom_range(1, 8), $urandom_range(6, 10));

        // Reset in the middle of a held press.
        ds = 4'd9;
        pushbutton1 = 1'b0;
        pushbutton2 = 1'b0;
        model_num = 4'd9;
        e.p1 = 1'b1; e.p2 = 1'b1; e.num = 4'd9;
        exp_q.push_back(e);
        cyc(8);
        check_eq("both_db_high", {pb1_db, pb2_db}, 2'b11);
        rst = 1'b1;
        cyc(1);
        check_eq("rst_press_db", {pb1_db, pb2_db}, 2'b00);
        check_eq("rst_press_num", entered_num, 0);
        pushbutton1 = 1'b1;
        pushbutton2 = 1'b1;
        cyc(1);
        rst = 1'b0;
        model_num = 4'd0;
        cyc(2);

        press(1, 4'd6, DB - 1, 8);
        check_eq("short_after_rst_num", entered_num, 0);
        press(2, 4'd11, 5, 8);
        check_eq("pb2_after_rst_num", entered_num, 0);
        press(1, 4'd14, DB, 8);

        for (int k = 0; k < 10; k++)
            press($urandom_range(1, 3), 4'($urandom), $urandom_range(3, 6), $urandom_range(6, 10));

        cyc(10);
        check_eq("queue_empty", exp_q.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
